// File: rtl/period_meter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : period_meter_pkg                                       |
// | Description : Shared constants and state encoding for period_meter   |
// |               and its neighbours in the components layer (the clock  |
// |               divider reuses CLOCK_HZ).                              |
// | Ports       : none (package)                                         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package period_meter_pkg;

  // System clock frequency, shared with the clock divider.
  localparam int CLOCK_HZ = 50_000_000;

  // 2^26 cycles at 50 MHz is just over 1.3 s, enough for a 1 s timeout.
  localparam int DEFAULT_COUNT_WIDTH    = 26;
  localparam int DEFAULT_TIMEOUT_CYCLES = CLOCK_HZ;
  localparam int DEFAULT_SYNC_STAGES    = 2;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/period_meter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : period_meter_if                                        |
// | Description : Control and result bundle of the period meter.         |
// | Ports       : enable, signal_in         (consumer -> meter)          |
// |               period, high_time,                                     |
// |               period_valid, timeout,                                 |
// |               measuring                 (meter -> consumer)          |
// |               master = meter side, slave = consumer side.            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface period_meter_if #(
  parameter int COUNT_WIDTH = period_meter_pkg::DEFAULT_COUNT_WIDTH
);
  logic                   enable;
  logic                   signal_in;
  logic [COUNT_WIDTH-1:0] period;
  logic [COUNT_WIDTH-1:0] high_time;
  logic                   period_valid;
  logic                   timeout;
  logic                   measuring;

  modport master (
    input  enable, signal_in,
    output period, high_time, period_valid, timeout, measuring
  );

  modport slave (
    output enable, signal_in,
    input  period, high_time, period_valid, timeout, measuring
  );
endinterface
`default_nettype wire

// File: rtl/period_meter_sync_edge_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sync_edge_detect                                       |
// | Description : Multi-flop synchronizer for an asynchronous level plus |
// |               a one-flop delayed copy for edge detection.            |
// |               Reusable for push buttons and similar slow inputs.     |
// | Ports       : clock, reset (sync, active high)                       |
// |               async_in  - asynchronous input                         |
// |               level     - synchronized level                         |
// |               rise/fall - single-cycle edge indications (comb)       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  wire  clock,
  input  wire  reset,
  input  wire  async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
      $error("sync_edge_detect: SYNC_STAGES must be at least 2");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   level_prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_chain <= '0;
      level_prev <= 1'b0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], async_in};
      level_prev <= sync_chain[SYNC_STAGES-1];
    end
  end

  assign level = sync_chain[SYNC_STAGES-1];
  assign rise  = level & ~level_prev;
  assign fall  = ~level & level_prev;

endmodule
`default_nettype wire

// File: rtl/period_meter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : period_meter                                           |
// | Description : Measures period and high time of a slow asynchronous   |
// |               signal in system clock cycles. Results update once per |
// |               completed cycle together with a one-cycle valid pulse; |
// |               a missing rising edge for TIMEOUT_CYCLES clears them.  |
// | Ports       : clock, reset (sync, active high)                       |
// |               bus (period_meter_if.master): enable, signal_in in;    |
// |               period, high_time, period_valid, timeout, measuring out|
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module period_meter
  import period_meter_pkg::*;
#(
  parameter int COUNT_WIDTH    = DEFAULT_COUNT_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int SYNC_STAGES    = DEFAULT_SYNC_STAGES
) (
  input  wire            clock,
  input  wire            reset,
  period_meter_if.master bus
);

  generate
    if (TIMEOUT_CYCLES <= 1 ||
        longint'(TIMEOUT_CYCLES) >= (longint'(1) << COUNT_WIDTH)) begin : g_bad_timeout
      $error("period_meter: TIMEOUT_CYCLES must satisfy 1 < TIMEOUT_CYCLES < 2**COUNT_WIDTH");
    end
  endgenerate

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE      = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] TIMEOUT_LAST = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic s;
  logic rise;
  logic unused_fall;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clock    (clock),
    .reset    (reset),
    .async_in (bus.signal_in),
    .level    (s),
    .rise     (rise),
    .fall     (unused_fall)
  );

  state_t                 state, state_next;
  logic [COUNT_WIDTH-1:0] cnt, cnt_next;
  logic [COUNT_WIDTH-1:0] hcnt, hcnt_next;
  logic [COUNT_WIDTH-1:0] period_q, period_next;
  logic [COUNT_WIDTH-1:0] high_q, high_next;
  logic                   valid_q, valid_next;
  logic                   timeout_q, timeout_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      hcnt      <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      hcnt      <= hcnt_next;
      period_q  <= period_next;
      high_q    <= high_next;
      valid_q   <= valid_next;
      timeout_q <= timeout_next;
    end
  end

  // cnt counts cycles since the last rise minus one, so the period is
  // cnt+1 at the next rise. hcnt starts at 1 because the rise cycle itself
  // already has s=1.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    hcnt_next    = hcnt;
    period_next  = period_q;
    high_next    = high_q;
    valid_next   = 1'b0;
    timeout_next = 1'b0;

    if (!bus.enable) begin
      // Abort without touching the held results.
      state_next = ST_IDLE;
      cnt_next   = '0;
      hcnt_next  = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rise) begin
            state_next = ST_MEASURE;
            cnt_next   = '0;
            hcnt_next  = CNT_ONE;
          end
        end
        ST_MEASURE: begin
          // A rise on the timeout cycle takes priority over the timeout.
          if (rise) begin
            period_next = cnt + CNT_ONE;
            high_next   = hcnt;
            valid_next  = 1'b1;
            cnt_next    = '0;
            hcnt_next   = CNT_ONE;
          end else if (cnt == TIMEOUT_LAST) begin
            timeout_next = 1'b1;
            period_next  = '0;
            high_next    = '0;
            state_next   = ST_IDLE;
            cnt_next     = '0;
            hcnt_next    = '0;
          end else begin
            cnt_next  = cnt + CNT_ONE;
            hcnt_next = hcnt + COUNT_WIDTH'(s);
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign bus.period       = period_q;
  assign bus.high_time    = high_q;
  assign bus.period_valid = valid_q;
  assign bus.timeout      = timeout_q;
  assign bus.measuring    = (state == ST_MEASURE);

endmodule
`default_nettype wire

// File: tb/tb_period_meter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_period_meter                                        |
// | Description : Self-checking bench for period_meter with COUNT_WIDTH=8|
// |               TIMEOUT_CYCLES=100, SYNC_STAGES=2. Steady waveforms    |
// |               come from a table; timeout, boundary, enable and reset |
// |               corners are hand-written sequences.                    |
// | Ports       : none                                                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_period_meter;

  localparam int CW = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;

  period_meter_if #(.COUNT_WIDTH(CW)) bus();

  period_meter #(
    .COUNT_WIDTH    (CW),
    .TIMEOUT_CYCLES (100),
    .SYNC_STAGES    (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_valid = 0;
  int n_to    = 0;
  int meas_ticks  = 0;
  int valid_stamp = 0;
  int to_stamp    = 0;
  int vp[$];
  int vh[$];

  typedef struct {
    int    high;
    int    low;
    int    reps;
    int    skip;       // leading valids that span the previous pattern
    int    min_valid;
    int    max_valid;
    int    exp_p;
    int    exp_h;
    string name;
  } seg_t;

  seg_t segs[4];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (bus.measuring === 1'b1) meas_ticks++;
    if (bus.period_valid === 1'b1) begin
      n_valid++;
      vp.push_back(int'(bus.period));
      vh.push_back(int'(bus.high_time));
      valid_stamp = cyc;
    end
    if (bus.timeout === 1'b1) begin
      n_to++;
      to_stamp = cyc;
    end
  endtask

  task automatic step(input logic v);
    bus.signal_in = v;
    tick();
  endtask

  task automatic wave(input int h, input int l, input int n);
    for (int r = 0; r < n; r++) begin
      for (int i = 0; i < h; i++) step(1'b1);
      for (int i = 0; i < l; i++) step(1'b0);
    end
  endtask

  task automatic clear_log();
    n_valid    = 0;
    n_to       = 0;
    meas_ticks = 0;
    vp.delete();
    vh.delete();
  endtask

  function automatic int vp_at(input int i);
    return (i < vp.size()) ? vp[i] : -1;
  endfunction

  function automatic int vh_at(input int i);
    return (i < vh.size()) ? vh[i] : -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int last_valid;
    int nv_before;

    segs[0] = '{10, 10,  6, 0,  5,  5, 20, 10, "sq50"};
    segs[1] = '{ 4, 12,  5, 1,  5,  5, 16,  4, "duty25"};
    segs[2] = '{ 8,  8,  4, 1,  4,  4, 16,  8, "duty50_16"};
    segs[3] = '{ 1,  1, 20, 1, 18, 20,  2,  1, "minperiod"};

    // Reset state
    bus.enable    = 1'b0;
    bus.signal_in = 1'b0;
    reset         = 1'b1;
    repeat (3) tick();
    check("reset period",       int'(bus.period),       0);
    check("reset high_time",    int'(bus.high_time),    0);
    check("reset period_valid", int'(bus.period_valid), 0);
    check("reset timeout",      int'(bus.timeout),      0);
    check("reset measuring",    int'(bus.measuring),    0);
    reset = 1'b0;
    bus.enable = 1'b1;
    repeat (3) step(1'b0);
    check("idle measuring", int'(bus.measuring), 0);

    // Steady waveforms from the table
    for (int k = 0; k < 4; k++) begin
      clear_log();
      wave(segs[k].high, segs[k].low, segs[k].reps);
      check_range({segs[k].name, " valid count"}, n_valid, segs[k].min_valid, segs[k].max_valid);
      check({segs[k].name, " timeout count"}, n_to, 0);
      check({segs[k].name, " measuring"}, int'(bus.measuring), 1);
      for (int i = segs[k].skip; i < vp.size(); i++) begin
        check($sformatf("%s period[%0d]", segs[k].name, i), vp[i], segs[k].exp_p);
        check($sformatf("%s high_time[%0d]", segs[k].name, i), vh[i], segs[k].exp_h);
      end
    end

    // Wave stops after a 20-cycle period: timeout 100 cycles after the valid
    clear_log();
    wave(10, 10, 3);
    check("stop last period", vp_at(vp.size() - 1), 20);
    check("stop last high",   vh_at(vh.size() - 1), 10);
    last_valid = valid_stamp;
    nv_before  = n_valid;
    for (int i = 0; i < 200 && n_to == 0; i++) step(1'b0);
    check("timeout seen",         n_to, 1);
    check("timeout delay",        to_stamp - last_valid, 100);
    check("timeout period",       int'(bus.period), 0);
    check("timeout high_time",    int'(bus.high_time), 0);
    check("timeout measuring",    int'(bus.measuring), 0);
    check("timeout no valid",     n_valid - nv_before, 0);

    // Restart: the first rise only starts measuring
    clear_log();
    wave(10, 10, 3);
    check("restart valid count", n_valid, 2);
    check("restart period",      vp_at(0), 20);
    check("restart high_time",   vh_at(0), 10);

    // Rise exactly on the cnt==99 cycle: period 100 and no timeout
    clear_log();
    wave(10, 90, 3);
    check("p100 valid count",   n_valid, 3);
    check("p100 period[1]",     vp_at(1), 100);
    check("p100 high_time[1]",  vh_at(1), 10);
    check("p100 period[2]",     vp_at(2), 100);
    check("p100 timeout count", n_to, 0);

    // enable low: idle, no pulses, results held
    bus.enable = 1'b0;
    clear_log();
    wave(10, 10, 5);
    check("disabled measuring ticks", meas_ticks, 0);
    check("disabled valid count",     n_valid, 0);
    check("disabled timeout count",   n_to, 0);
    check("disabled period held",     int'(bus.period), 100);
    check("disabled high held",       int'(bus.high_time), 10);

    bus.enable = 1'b1;
    clear_log();
    wave(10, 10, 3);
    check("reenable valid count", n_valid, 2);
    check("reenable period",      vp_at(0), 20);

    // Reset for one cycle in the middle of a period
    for (int i = 0; i < 10; i++) step(1'b1);
    for (int i = 0; i < 5; i++) step(1'b0);
    check("pre-reset period", int'(bus.period), 20);
    reset = 1'b1;
    step(1'b0);
    check("midreset period",       int'(bus.period),       0);
    check("midreset high_time",    int'(bus.high_time),    0);
    check("midreset period_valid", int'(bus.period_valid), 0);
    check("midreset timeout",      int'(bus.timeout),      0);
    check("midreset measuring",    int'(bus.measuring),    0);
    reset = 1'b0;
    clear_log();
    repeat (3) step(1'b0);
    wave(10, 10, 3);
    check("postreset valid count", n_valid, 2);
    check("postreset period",      vp_at(0), 20);
    check("postreset high_time",   vh_at(0), 10);
    check("postreset timeouts",    n_to, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/period_meter.md
Name: period_meter

Overview:
- Inverse of the system's clock division: measures an incoming slow periodic signal in units of the 50 MHz system clock.
- Typical input: a divided clock, rotary/encoder line or external square wave.
- Reports the full period and the high time once per completed cycle, with a one-cycle valid strobe.
- Sits beside the clock divider in the components layer; game logic uses it for tempo/frequency checks and self-test of divided clocks.

Parameters:
- COUNT_WIDTH, 26, width of all counters and results; 2^26 exceeds 1 s at 50 MHz.
- TIMEOUT_CYCLES, 50000000, cycles without a rising edge before measurement is abandoned. Must satisfy 1 < TIMEOUT_CYCLES < 2^COUNT_WIDTH; elaboration error otherwise.
- SYNC_STAGES, 2, synchronizer depth for signal_in; minimum 2.

Ports:
- clock  input  1  system clock, 50 MHz
- reset  input  1  synchronous, active-high reset
- enable  input  1  1 = measure; 0 = abort to IDLE, hold results
- signal_in  input  1  asynchronous signal to measure
- period  output  COUNT_WIDTH  last measured period in clock cycles
- high_time  output  COUNT_WIDTH  cycles synchronized input was 1 within that period
- period_valid  output  1  one-cycle pulse when period/high_time update
- timeout  output  1  one-cycle pulse when TIMEOUT_CYCLES elapse without a rising edge
- measuring  output  1  1 while in MEASURE state

Behaviour:
- Synchronizer and edge detection
  - signal_in passes through SYNC_STAGES flops giving s, then one more flop giving s_prev.
  - rise = s & ~s_prev (combinational).
  - Latency from signal_in to rise: SYNC_STAGES+1 clocks.
  - No glitch filtering; pulses shorter than one clock may be missed.
- Reset
  - Clears all flops: sync chain, s_prev, counters, state=IDLE.
  - Clears outputs: period=0, high_time=0, period_valid=0, timeout=0, measuring=0.
  - If signal_in is high at reset release, a rise is seen after synchronization. It only starts a measurement and never produces valid.
- Counters: cnt (period) and hcnt (high time), both COUNT_WIDTH.
- State IDLE (measuring=0)
  - rise & enable -> MEASURE, cnt<=0, hcnt<=1. No valid pulse.
- State MEASURE (measuring=1)
  - Each cycle without rise: cnt<=cnt+1 and hcnt<=hcnt+s.
  - On rise:
    - period<=cnt+1 and high_time<=hcnt.
    - period_valid<=1 for exactly the next cycle.
    - cnt<=0, hcnt<=1, stay in MEASURE.
  - Result: rises N cycles apart give period=N.
  - Timeout: no rise while cnt==TIMEOUT_CYCLES-1 ->
    - timeout pulse for one cycle.
    - period<=0, high_time<=0.
    - -> IDLE, no valid.
  - Rise on the same cycle as the timeout condition: rise wins (normal update, no timeout).
- enable=0
  - Any state -> IDLE next cycle; counters cleared.
  - period/high_time hold their last values; no valid or timeout pulse.
  - Synchronizer keeps running.
- Restart after IDLE: the first rise restarts the measurement; valid comes on the second rise.
- Outputs are registered; results change only together with period_valid, or with timeout (cleared to 0).
- Counters never wrap: the timeout bound keeps cnt < 2^COUNT_WIDTH-1.
- Minimum measurable period: 2 cycles.

Decomposition:
- Shared package/include holds:
  - state encoding constants (ST_IDLE=0, ST_MEASURE=1);
  - default COUNT_WIDTH;
  - CLOCK_HZ=50000000, shared with the clock divider.
- One natural sub-module, sync_edge_detect: parameter SYNC_STAGES; ports clock, reset, async_in, level, rise, fall. Reusable for buttons.

Test Plan (bench overrides COUNT_WIDTH=8, TIMEOUT_CYCLES=100, SYNC_STAGES=2):
- 50% square wave, 10 high/10 low, enable=1:
  - no valid after the first rise;
  - each later rise: period_valid pulse with period=20, high_time=10;
  - measuring=1 throughout.
- 25% duty, 4 high/12 low: every valid gives period=16, high_time=4. Then switch to 8/8: the first valid after the switch spans the transition; the next gives 16/8.
- Minimum period, signal_in toggling every clock: valid every 2 cycles with period=2, high_time=1.
- Wave stops after a valid (period=20), signal held low:
  - timeout pulse exactly 100 cycles after the last rise;
  - period=0 and high_time=0, measuring=0;
  - on restart the first rise gives no valid; the second rise gives valid.
- Rise arriving exactly on the cnt==99 cycle: period_valid with period=100, no timeout pulse.
- reset held 1 cycle mid-period:
  - all outputs 0 the next cycle;
  - the next rise gives no valid; the following rise gives a correct valid.
- enable dropped mid-period: measuring=0 and no pulses while low; period holds its prior value.
